// File: rtl/ibex_dit_timing_monitor_if.sv
// Per-channel execution-unit handshake seen by the DIT timing monitor.
// The master side drives start/valid/ready; the monitor reports busy/done.
interface ibex_dit_timing_monitor_if #(
  parameter int unsigned NumChan = 2
);
  logic [NumChan-1:0] start_i;
  logic [NumChan-1:0] valid_i;
  logic [NumChan-1:0] ready_i;
  logic [NumChan-1:0] busy_o;
  logic [NumChan-1:0] done_o;

  modport master (
    output start_i, valid_i, ready_i,
    input  busy_o, done_o
  );

  modport slave (
    input  start_i, valid_i, ready_i,
    output busy_o, done_o
  );
endinterface

// File: rtl/ibex_dit_timing_monitor.sv
// Start-to-valid latency monitor with sticky DIT-mismatch, timeout and protocol flags.
// Define IBEX_DIT_MONITOR_ASSERT_EN to add per-channel concurrent assertions on each error.
module ibex_dit_timing_monitor #(
  parameter int unsigned NumChan = 2,
  parameter int unsigned CntW    = 6,
  parameter int unsigned MaxLat  = 40
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  ibex_dit_timing_monitor_if.slave  hs,
  input  logic                      data_ind_timing_i,
  input  logic [NumChan*CntW-1:0]   exp_lat_i,
  input  logic                      clr_i,
  output logic [NumChan*CntW-1:0]   lat_o,
  output logic [NumChan-1:0]        err_mismatch_o,
  output logic [NumChan-1:0]        err_timeout_o,
  output logic [NumChan-1:0]        err_protocol_o
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_e;

  localparam logic [CntW-1:0] CntSat     = '1;
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(MaxLat + 1);

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] exp_q, exp_d;
    logic [CntW-1:0] lat_q, lat_d;
    logic            dit_q, dit_d;
    logic            busy_q, done_q, done_d;
    logic            mm_q, to_q, pr_q;
    logic            mm_set, to_set, pr_set;
    logic            start, valid, ready;

    assign start = hs.start_i[c];
    assign valid = hs.valid_i[c];
    assign ready = hs.ready_i[c];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        exp_q   <= '0;
        dit_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        exp_q   <= exp_d;
        dit_q   <= dit_d;
      end
    end

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        IDLE:    if (start) state_d = COUNT;
        COUNT: begin
          if (valid)                    state_d = ready ? IDLE : HOLD;
          else if (cnt_q == TimeoutCnt) state_d = IDLE;
        end
        HOLD:    if (!valid || ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // A start while busy only flags an error; the running measurement is kept.
    always_comb begin
      cnt_d  = cnt_q;
      exp_d  = exp_q;
      dit_d  = dit_q;
      lat_d  = lat_q;
      done_d = 1'b0;
      mm_set = 1'b0;
      to_set = 1'b0;
      pr_set = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d = CntW'(1);
            exp_d = exp_lat_i[c*CntW +: CntW];
            dit_d = data_ind_timing_i;
          end
        end
        COUNT: begin
          pr_set = start;
          if (valid) begin
            lat_d  = cnt_q;
            mm_set = dit_q && (cnt_q != exp_q);
            done_d = ready;
          end else if (cnt_q == TimeoutCnt) begin
            to_set = 1'b1;
          end else if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        HOLD: begin
          pr_set = start || !valid;
          done_d = valid && ready;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        busy_q <= 1'b0;
        done_q <= 1'b0;
        lat_q  <= '0;
        mm_q   <= 1'b0;
        to_q   <= 1'b0;
        pr_q   <= 1'b0;
      end else begin
        busy_q <= (state_d != IDLE);
        done_q <= done_d;
        lat_q  <= lat_d;
        mm_q   <= mm_set || (mm_q && !clr_i);
        to_q   <= to_set || (to_q && !clr_i);
        pr_q   <= pr_set || (pr_q && !clr_i);
      end
    end

    assign hs.busy_o[c]            = busy_q;
    assign hs.done_o[c]            = done_q;
    assign lat_o[c*CntW +: CntW]   = lat_q;
    assign err_mismatch_o[c]       = mm_q;
    assign err_timeout_o[c]        = to_q;
    assign err_protocol_o[c]       = pr_q;

`ifdef IBEX_DIT_MONITOR_ASSERT_EN
    MismatchA: assert property (@(posedge clk_i) disable iff (!rst_ni) !mm_set);
    TimeoutA:  assert property (@(posedge clk_i) disable iff (!rst_ni) !to_set);
    ProtocolA: assert property (@(posedge clk_i) disable iff (!rst_ni) !pr_set);
`else
    // Errors are reported on the sticky outputs only.
`endif
  end

endmodule

// File: tb/tb_ibex_dit_timing_monitor.sv
// Directed table-driven bench for ibex_dit_timing_monitor (NumChan=2, CntW=6, MaxLat=40).
module tb_ibex_dit_timing_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dit = 1'b0;
  logic [11:0] exp_lat = '0;
  logic        clr = 1'b0;
  logic [11:0] lat;
  logic [1:0]  err_mm, err_to, err_pr;

  int n_tests = 0;
  int n_fail  = 0;

  ibex_dit_timing_monitor_if #(.NumChan(2)) hs ();

  ibex_dit_timing_monitor #(.NumChan(2), .CntW(6), .MaxLat(40)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .hs                (hs),
    .data_ind_timing_i (dit),
    .exp_lat_i         (exp_lat),
    .clr_i             (clr),
    .lat_o             (lat),
    .err_mismatch_o    (err_mm),
    .err_timeout_o     (err_to),
    .err_protocol_o    (err_pr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       rst;
    logic [1:0] start, valid, ready;
    logic       dit;
    logic [5:0] e0, e1;
    logic       clr;
    logic [1:0] busy, done;
    logic [5:0] l0, l1;
    logic [1:0] mm, to, pr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(int n, logic r, logic [1:0] st, logic [1:0] va, logic [1:0] rd,
                     logic d, logic [5:0] e0, logic [5:0] e1, logic c,
                     logic [1:0] busy, logic [1:0] done, logic [5:0] l0, logic [5:0] l1,
                     logic [1:0] mm, logic [1:0] to, logic [1:0] pr);
    vec_t v;
    v.n = n; v.rst = r; v.start = st; v.valid = va; v.ready = rd; v.dit = d;
    v.e0 = e0; v.e1 = e1; v.clr = c; v.busy = busy; v.done = done;
    v.l0 = l0; v.l1 = l1; v.mm = mm; v.to = to; v.pr = pr;
    vecs.push_back(v);
  endtask

  function automatic logic [21:0] outs();
    return {hs.busy_o, hs.done_o, lat, err_mm, err_to, err_pr};
  endfunction

  task automatic check(string name, logic [21:0] act, logic [21:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got busy/done/lat1/lat0/mm/to/pr=%b_%b_%0d_%0d_%b_%b_%b required %b_%b_%0d_%0d_%b_%b_%b",
               name, act[21:20], act[19:18], act[17:12], act[11:6], act[5:4], act[3:2], act[1:0],
               req[21:20], req[19:18], req[17:12], req[11:6], req[5:4], req[3:2], req[1:0]);
    end
  endtask

  task automatic drive(logic r, logic [1:0] st, logic [1:0] va, logic [1:0] rd,
                       logic d, logic [5:0] e0, logic [5:0] e1, logic c);
    rst_n = r; hs.start_i = st; hs.valid_i = va; hs.ready_i = rd;
    dit = d; exp_lat = {e1, e0}; clr = c;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  n  rst st    va    rd    dit e0  e1 clr  busy  done  l0  l1  mm    to    pr
    add(1, 1, 2'b01, 2'b00, 2'b00, 1, 34, 0, 0, 2'b01, 2'b00,  0,  0, 2'b00, 2'b00, 2'b00); // 0 DIT exp=34
    add(33,1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00,  0,  0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b01, 2'b01, 0,  0, 0, 0, 2'b00, 2'b01, 34,  0, 2'b00, 2'b00, 2'b00); // match at T+34
    add(1, 1, 2'b01, 2'b00, 2'b00, 0, 34, 0, 0, 2'b01, 2'b00, 34,  0, 2'b00, 2'b00, 2'b00); // back-to-back, DIT=0
    add(9, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00, 34,  0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b01, 2'b01, 0,  0, 0, 0, 2'b00, 2'b01, 10,  0, 2'b00, 2'b00, 2'b00); // no error w/o DIT
    add(1, 1, 2'b01, 2'b00, 2'b00, 1, 34, 0, 0, 2'b01, 2'b00, 10,  0, 2'b00, 2'b00, 2'b00);
    add(9, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00, 10,  0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b01, 2'b01, 0,  0, 0, 0, 2'b00, 2'b01, 10,  0, 2'b01, 2'b00, 2'b00); // mismatch
    add(1, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 1, 2'b00, 2'b00, 10,  0, 2'b00, 2'b00, 2'b00); // clear
    add(1, 1, 2'b00, 2'b01, 2'b01, 0,  0, 0, 0, 2'b00, 2'b00, 10,  0, 2'b00, 2'b00, 2'b00); // valid in IDLE ignored
    add(1, 1, 2'b01, 2'b00, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00, 10,  0, 2'b00, 2'b00, 2'b00);
    add(4, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00, 10,  0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b01, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00,  5,  0, 2'b00, 2'b00, 2'b00); // HOLD
    add(1, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b00, 2'b00,  5,  0, 2'b00, 2'b00, 2'b01); // valid dropped
    add(1, 1, 2'b01, 2'b00, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00,  5,  0, 2'b00, 2'b00, 2'b01);
    add(1, 1, 2'b00, 2'b01, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00,  1,  0, 2'b00, 2'b00, 2'b01);
    add(1, 1, 2'b00, 2'b01, 2'b01, 0,  0, 0, 0, 2'b00, 2'b01,  1,  0, 2'b00, 2'b00, 2'b01); // HOLD -> done
    add(1, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 1, 2'b00, 2'b00,  1,  0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 2'b00, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00,  1,  0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 2'b00, 2'b00, 0,  0, 0, 1, 2'b01, 2'b00,  1,  0, 2'b00, 2'b00, 2'b01); // set beats clr
    add(1, 1, 2'b00, 2'b01, 2'b01, 0,  0, 0, 0, 2'b00, 2'b01,  2,  0, 2'b00, 2'b00, 2'b01);
    add(1, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 1, 2'b00, 2'b00,  2,  0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b11, 2'b00, 2'b00, 0,  0, 0, 0, 2'b11, 2'b00,  2,  0, 2'b00, 2'b00, 2'b00); // both channels
    add(2, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b11, 2'b00,  2,  0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b10, 2'b00, 2'b00, 0,  0, 0, 0, 2'b11, 2'b00,  2,  0, 2'b00, 2'b00, 2'b10); // ch1 overlap
    add(1, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b11, 2'b00,  2,  0, 2'b00, 2'b00, 2'b10);
    add(1, 1, 2'b00, 2'b10, 2'b10, 0,  0, 0, 0, 2'b01, 2'b10,  2,  5, 2'b00, 2'b00, 2'b10);
    add(1, 1, 2'b00, 2'b01, 2'b01, 0,  0, 0, 0, 2'b00, 2'b01,  6,  5, 2'b00, 2'b00, 2'b10);
    add(1, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 1, 2'b00, 2'b00,  6,  5, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b10, 2'b00, 2'b00, 0,  0, 0, 0, 2'b10, 2'b00,  6,  5, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b10, 2'b10, 2'b10, 0,  0, 0, 0, 2'b00, 2'b10,  6,  1, 2'b00, 2'b00, 2'b10); // start on handshake
    add(1, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 1, 2'b00, 2'b00,  6,  1, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b01, 2'b00, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00,  6,  1, 2'b00, 2'b00, 2'b00); // timeout run
    add(40,1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00,  6,  1, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b00, 2'b00,  6,  1, 2'b00, 2'b01, 2'b00);
    add(1, 1, 2'b01, 2'b00, 2'b00, 1,  3, 0, 1, 2'b01, 2'b00,  6,  1, 2'b00, 2'b00, 2'b00);
    add(3, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00,  6,  1, 2'b00, 2'b00, 2'b00);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b00, 2'b00,  0,  0, 2'b00, 2'b00, 2'b00); // reset in COUNT
    add(1, 1, 2'b01, 2'b00, 2'b00, 1,  3, 0, 0, 2'b01, 2'b00,  0,  0, 2'b00, 2'b00, 2'b00);
    add(2, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b01, 2'b00,  0,  0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b01, 2'b01, 0,  0, 0, 0, 2'b00, 2'b01,  3,  0, 2'b00, 2'b00, 2'b00);
    add(1, 1, 2'b10, 2'b00, 2'b00, 1,  0, 2, 0, 2'b10, 2'b00,  3,  0, 2'b00, 2'b00, 2'b00); // ch1 DIT lane
    add(1, 1, 2'b00, 2'b10, 2'b10, 0,  0, 0, 0, 2'b00, 2'b10,  3,  1, 2'b10, 2'b00, 2'b00);
    add(1, 1, 2'b00, 2'b00, 2'b00, 0,  0, 0, 0, 2'b00, 2'b00,  3,  1, 2'b10, 2'b00, 2'b00);

    drive(0, '0, '0, '0, 0, 0, 0, 0);
    cycle();
    cycle();
    check("reset", outs(), '0);
    drive(1, '0, '0, '0, 0, 0, 0, 0);
    cycle();

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        drive(vecs[i].rst, vecs[i].start, vecs[i].valid, vecs[i].ready,
              vecs[i].dit, vecs[i].e0, vecs[i].e1, vecs[i].clr);
        cycle();
      end
      check($sformatf("row%0d", i), outs(),
            {vecs[i].busy, vecs[i].done, vecs[i].l1, vecs[i].l0,
             vecs[i].mm, vecs[i].to, vecs[i].pr});
    end

    // Asynchronous reset mid-measurement, checked before any clock edge.
    drive(1, 2'b10, '0, '0, 1, 0, 5, 0);
    cycle();
    drive(1, '0, '0, '0, 0, 0, 0, 0);
    cycle();
    check("busy_before_async_rst", outs(), {2'b10, 2'b00, 6'd1, 6'd3, 2'b10, 2'b00, 2'b00});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst", outs(), '0);
    cycle();
    drive(1, 2'b10, '0, '0, 1, 0, 5, 0);
    cycle();
    drive(1, '0, '0, '0, 0, 0, 0, 0);
    repeat (4) cycle();
    drive(1, '0, 2'b10, 2'b10, 0, 0, 0, 0);
    cycle();
    check("post_rst_measure", outs(), {2'b00, 2'b10, 6'd5, 6'd0, 2'b00, 2'b00, 2'b00});
    drive(1, '0, '0, '0, 0, 0, 0, 0);
    cycle();
    check("post_rst_idle", outs(), {2'b00, 2'b00, 6'd5, 6'd0, 2'b00, 2'b00, 2'b00});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_dit_timing_monitor.md
# ibex_dit_timing_monitor

Parametrised, synthesisable latency monitor for multi-cycle execution units such as the multiplier/divider. It measures start-to-valid latency on `NumChan` independent channels and flags three conditions: a latency mismatch while data-independent timing is enabled, a timeout, or a handshake violation. It sits beside the execution units in the ID/EX stage, drives no datapath signals, and can be used in simulation, in formal checking, or left in silicon as a fault detector.

## Interface
- `NumChan`, 2, number of independently monitored units.
- `CntW`, 6, latency counter width.
- `MaxLat`, 40, timeout bound in cycles; must satisfy `MaxLat < 2**CntW - 1`.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  NumChan  per-channel operation start, single-cycle pulse.
- `valid_i`  in  NumChan  per-channel result valid.
- `ready_i`  in  NumChan  per-channel consumer ready.
- `data_ind_timing_i`  in  1  DIT mode; sampled per channel when that channel starts.
- `exp_lat_i`  in  NumChan*CntW  expected DIT latency; channel c occupies bits [c*CntW +: CntW]; sampled at start.
- `clr_i`  in  1  synchronous clear of all sticky error flags.
- `busy_o`  out  NumChan  channel is not idle.
- `done_o`  out  NumChan  one-cycle pulse when a result handshake completes.
- `lat_o`  out  NumChan*CntW  last measured latency per channel.
- `err_mismatch_o`  out  NumChan  sticky: DIT latency differed from the expected value.
- `err_timeout_o`  out  NumChan  sticky: no valid within `MaxLat` cycles.
- `err_protocol_o`  out  NumChan  sticky: start while busy, or valid dropped before ready.

## Operation
- Each channel runs its own FSM with states IDLE, COUNT and HOLD.
- IDLE:
  - On `start_i[c]`: set cnt=1, capture the DIT mode and `exp_lat_i`, go to COUNT.
  - `valid_i` while IDLE is ignored.
- COUNT:
  - cnt increments each cycle and saturates at `2**CntW-1`.
  - On `valid_i[c]`: write cnt to `lat_o`. If the captured DIT mode is 1 and cnt != captured expected latency, set `err_mismatch_o`.
  - If valid and ready in the same cycle: go to IDLE and pulse `done_o`.
  - If valid without ready: go to HOLD.
  - If cnt reaches `MaxLat+1` without valid: set `err_timeout_o` and go to IDLE.
- HOLD:
  - Valid with ready: go to IDLE and pulse `done_o`.
  - Valid dropped: set `err_protocol_o` and go to IDLE.
- `start_i[c]` in COUNT or HOLD: set `err_protocol_o`. The current measurement continues and the start is ignored.
- Latency definition: start in cycle T and valid in cycle T+L gives latency L. Valid in the same cycle as start is not observed.
- Error flags:
  - Set has priority over `clr_i` in the same cycle.
  - Flags only clear through `clr_i` or reset.
- Channels are fully independent; there is no arbitration between them.

## Timing
- Reset values: all FSMs in IDLE, cnt=0. `busy_o`, `done_o`, `lat_o` and all error outputs are 0.
- Reset may assert in any state. The abandoned measurement raises no error.
- All outputs are registered.
- Error flags, `lat_o` and `done_o` appear in the cycle after the triggering input.
- `busy_o` rises in the cycle after start. It falls in the cycle after the completing handshake, the timeout, or the protocol abort.
- Back-to-back operation: a start in the cycle after `done_o` is legal. A start in the same cycle as the completing handshake is a protocol error, because the channel is still busy.

## Configuration
- `IBEX_DIT_MONITOR_ASSERT_EN`
  - Defined: adds concurrent assertions per channel, one for each error condition (mismatch, timeout, protocol). They fire in simulation and formal, and are disabled while `rst_ni` is low.
  - Undefined: errors are reported only on the outputs, and the RTL is assertion-free for synthesis.

## Test plan
- Matching DIT latency: channel 0, DIT=1, exp=34, start at T, valid+ready at T+34 -> `lat_o[0]`=34, `done_o[0]` pulses at T+35, no errors.
- DIT mismatch: DIT=1, exp=34, valid at T+10 -> `err_mismatch_o[0]`=1 and `lat_o[0]`=10. The same stimulus with DIT=0 raises no error.
- Timeout: start with no valid -> `err_timeout_o` rises in the cycle after cnt reaches 41 (`MaxLat+1`), and `busy_o` falls.
- HOLD drop: valid at T+5 with ready=0, valid deasserted at T+6 -> `err_protocol_o`=1, channel returns to IDLE.
- Overlap and independence: start on channel 1 at T and again at T+3 -> channel 1 raises a protocol error and still measures latency from T. Channel 0 running concurrently is unaffected.
- Reset and clear:
  - `rst_ni` low in COUNT -> all outputs 0, and a new start measures correctly.
  - `clr_i` in the same cycle as a new error -> the flag stays set.
